discrete_node_scheduler: RTL and testbench
==========================================

# discrete_node_scheduler

Time-multiplexed update engine for first-order discrete-circuit nodes, e.g. 555 control-voltage nodes and RC filters. On each audio sample strobe it steps NODES node models through one shared multiply-accumulate datapath, evaluating `state' = a*state + b0*in0 + b1*in1 + b2*in2` per node. It holds the per-node coefficient set and exposes a configuration write port. It sits between the sample-rate divider and the audio mixer.

## Interface
- NODES, 4, number of node models, 1..16
- DW, 16, data width of inputs, states and outputs (signed)
- COEF_FRAC, 14, fractional bits of coefficients (signed Q1.14)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sample_en  in  1  one-cycle sample strobe
- node_in  in  NODES*3*DW  per-node inputs; node n input k at bits [(n*3+k)*DW +: DW]
- cfg_we  in  1  coefficient write request
- cfg_addr  in  $clog2(NODES*4)  address n*4+k; k=0 is a, k=1..3 are b0..b2
- cfg_data  in  DW  coefficient value
- cfg_ready  out  1  high when writes are accepted
- v_out  out  NODES*DW  node states, updated once per frame
- out_valid  out  1  one-cycle pulse when v_out is updated
- busy  out  1  frame in progress
- overrun  out  1  sticky; a sample_en arrived while busy

## Operation
- FSM states: IDLE, SNAP, MAC, WB, DONE.
- **IDLE**
  - busy=0, cfg_ready=1.
  - On sample_en, go to SNAP.
- **SNAP**
  - Capture all of node_in into a snapshot register. Inputs are consistent for the whole frame.
  - Clear the accumulator and set node=0, k=0.
- **MAC** (4 cycles per node)
  - k=0: acc += state[n]*a[n]
  - k=1..3: acc += snap_in[n][k-1]*b[k-1][n]
- **WB**
  - res = acc >>> COEF_FRAC, saturated to the signed DW range.
  - Write res to state[n] and clear acc.
  - If n = NODES-1, go to DONE. Otherwise n+1, back to MAC with k=0.
- **DONE**
  - Copy all states to v_out and pulse out_valid.
  - Return to IDLE.
- Arithmetic
  - Products are signed DW x DW to 2*DW bits.
  - The accumulator is 2*DW+3 bits and never wraps.
  - Shifting is arithmetic (truncation toward -inf) and is followed by saturation.
- Configuration writes
  - Accepted only when cfg_we && cfg_ready. They take effect the next cycle.
  - cfg_we while busy is ignored with no effect. Requesters must hold it until cfg_ready.
  - cfg_addr >= NODES*4 is ignored.
- Sample collisions
  - sample_en while busy=1 (SNAP..DONE) is dropped and sets overrun.
  - overrun clears only on rst.
  - sample_en and cfg_we together in IDLE: the write is accepted and the frame starts. The frame uses the new coefficient, since the first MAC is at least 2 cycles later.

## Timing
- sample_en seen in IDLE at cycle T gives:
  - SNAP at T+1
  - node n MAC at T+2+5n .. T+5+5n, and WB at T+6+5n
  - DONE and out_valid at T+2+5*NODES (NODES=4: T+22)
  - IDLE at T+3+5*NODES
- busy=1 from T+1 through T+2+5*NODES inclusive.
- Minimum sample period is 3+5*NODES cycles with no overrun.
- v_out changes only in the cycle out_valid is high, and holds between frames.
- Reset values: v_out=0, all states=0, all coefficients=0, out_valid=0, busy=0, overrun=0, cfg_ready=1, FSM=IDLE.
- rst mid-frame aborts the frame. All of the above apply next cycle, with no out_valid.

## Structure
- Package discrete_sched_pkg:
  - state enum
  - DW and COEF_FRAC defaults
  - sat_dw() function
  - coefficient address encoding (k field constants)
- Sub-module discrete_mac:
  - registered signed multiply-accumulate with clear and enable
  - one instance, shared by all nodes
- Storage:
  - coefficients in a NODES*4 x DW register file
  - states in a NODES x DW register file
  - both are small enough for flops, with no RAM inference required

## Test plan
- **Reset and idle**
  - Stimulus: rst held, then released with no sample_en.
  - Required: v_out=0, out_valid=0, busy=0, cfg_ready=1, overrun=0.
- **Single node integrate**
  - Stimulus: node0 a=16384 (1.0), b0=8192 (0.5), in0=1000; two sample_en strobes 40 cycles apart.
  - Required: v_out[0]=500, then 1000. out_valid at T+22 each frame. Other nodes stay 0.
- **Saturation**
  - Stimulus: node1 b0=b1=b2=32767, in0..2=32767, then in0..2=-32768.
  - Required: v_out[1]=32767, then saturates to -32768. No wrap.
- **Overrun**
  - Stimulus: second sample_en at T+10.
  - Required: overrun=1 sticky, frame completes normally, exactly one out_valid.
- **Config during busy**
  - Stimulus: cfg_we to address 0 at T+5, held until cfg_ready.
  - Required: the write lands at T+23. The current frame uses the old a; the next frame uses the new a.
- **Reset mid-frame**
  - Stimulus: rst at T+12.
  - Required: no out_valid, states and coefficients zeroed. A new sample_en works from IDLE.

Source files
------------

// File: rtl/discrete_sched_pkg.sv
// Shared definitions for the discrete node scheduler.
// Contents:
//   - sched_state_e : frame sequencer states
//   - DefDw / DefCoefFrac : default data width and coefficient fraction bits
//   - KField*       : k field of a coefficient address (addr = node*4 + k)
//   - sat_dw()      : clamp a value to the signed range of a dw-bit word
package discrete_sched_pkg;

  localparam int unsigned DefDw       = 16;
  localparam int unsigned DefCoefFrac = 14;

  // Coefficient slot within a node's group of four.
  localparam logic [1:0] KFieldA  = 2'd0;
  localparam logic [1:0] KFieldB0 = 2'd1;
  localparam logic [1:0] KFieldB1 = 2'd2;
  localparam logic [1:0] KFieldB2 = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StSnap,
    StMac,
    StWb,
    StDone
  } sched_state_e;

  function automatic longint sat_dw(input longint value, input int unsigned dw);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (dw - 1)) - 1;
    lo = -hi - 1;
    if (value > hi) begin
      sat_dw = hi;
    end else if (value < lo) begin
      sat_dw = lo;
    end else begin
      sat_dw = value;
    end
  endfunction

endpackage

// File: rtl/discrete_node_scheduler_mac.sv
// Registered signed multiply-accumulate shared by all node models.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero the accumulator (wins over en)
//   en       : add a*b to the accumulator
//   a, b     : signed DW-bit operands
//   acc      : signed AW-bit accumulator
module discrete_mac #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 2 * DW + 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [AW-1:0] acc
);

  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   prod_ext;

  assign prod     = a * b;
  assign prod_ext = {{(AW - 2 * DW){prod[2*DW-1]}}, prod};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/discrete_node_scheduler.sv
// Time-multiplexed first-order node update engine. Each sample strobe steps every node
// through state' = a*state + b0*in0 + b1*in1 + b2*in2 on one shared MAC.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   sample_en : one-cycle frame start strobe
//   node_in   : per-node inputs, node n input k at [(n*3+k)*DW +: DW]
//   cfg_we/cfg_addr/cfg_data : coefficient write (addr = n*4+k, k=0 a, 1..3 b0..b2)
//   cfg_ready : writes accepted (idle only)
//   v_out     : node states, refreshed once per frame
//   out_valid : one-cycle pulse when v_out refreshes
//   busy      : frame in progress
//   overrun   : sticky, strobe arrived while busy
module discrete_node_scheduler
  import discrete_sched_pkg::*;
#(
  parameter int unsigned NODES     = 4,
  parameter int unsigned DW        = DefDw,
  parameter int unsigned COEF_FRAC = DefCoefFrac
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sample_en,
  input  logic [NODES*3*DW-1:0]       node_in,
  input  logic                        cfg_we,
  input  logic [$clog2(NODES*4)-1:0]  cfg_addr,
  input  logic [DW-1:0]               cfg_data,
  output logic                        cfg_ready,
  output logic [NODES*DW-1:0]         v_out,
  output logic                        out_valid,
  output logic                        busy,
  output logic                        overrun
);

  localparam int unsigned NumCoef = NODES * 4;
  localparam int unsigned NumSnap = NODES * 3;
  localparam int unsigned AddrW   = $clog2(NumCoef);
  localparam int unsigned SnapW   = $clog2(NumSnap);
  localparam int unsigned NodeW   = (NODES > 1) ? $clog2(NODES) : 1;
  localparam int unsigned AccW    = 2 * DW + 3;

  sched_state_e fsm_q, fsm_d;
  logic [NodeW-1:0]     node_q;
  logic [1:0]           k_q;
  logic                 overrun_q;
  logic signed [DW-1:0] coef_q       [NumCoef];
  logic signed [DW-1:0] node_state_q [NODES];
  logic signed [DW-1:0] snap_q       [NumSnap];
  logic signed [DW-1:0] vout_q       [NODES];

  int unsigned          node_idx, k_idx;
  logic [SnapW-1:0]     snap_idx;
  logic [AddrW-1:0]     coef_idx;
  logic signed [DW-1:0] mac_x, mac_y, res;
  logic signed [AccW-1:0] acc, acc_shr;
  logic                 last_node, mac_en, mac_clr;

  assign node_idx  = 32'(node_q);
  assign k_idx     = 32'(k_q);
  assign last_node = (node_q == NodeW'(NODES - 1));
  assign busy      = (fsm_q != StIdle);
  assign cfg_ready = ~busy;
  assign out_valid = (fsm_q == StDone);
  assign overrun   = overrun_q;
  assign mac_en    = (fsm_q == StMac);
  assign mac_clr   = (fsm_q == StSnap) || (fsm_q == StWb);

  for (genvar n = 0; n < NODES; n++) begin : g_vout
    assign v_out[n*DW +: DW] = vout_q[n];
  end

  // Operand select: k=0 feeds back the node state, k=1..3 pick the frozen inputs.
  always_comb begin
    snap_idx = '0;
    coef_idx = AddrW'(node_idx * 4 + k_idx);
    if (k_q == KFieldA) begin
      mac_x = node_state_q[node_q];
    end else begin
      snap_idx = SnapW'(node_idx * 3 + k_idx - 1);
      mac_x    = snap_q[snap_idx];
    end
    mac_y = coef_q[coef_idx];
  end

  discrete_mac #(
    .DW (DW),
    .AW (AccW)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (mac_x),
    .b   (mac_y),
    .acc (acc)
  );

  // Arithmetic shift floors toward -inf before clamping.
  assign acc_shr = acc >>> COEF_FRAC;
  assign res     = DW'(sat_dw(longint'(acc_shr), DW));

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      StIdle: if (sample_en) fsm_d = StSnap;
      StSnap: fsm_d = StMac;
      StMac:  if (k_q == KFieldB2) fsm_d = StWb;
      StWb:   fsm_d = last_node ? StDone : StMac;
      StDone: fsm_d = StIdle;
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= StIdle;
      node_q    <= '0;
      k_q       <= '0;
      overrun_q <= 1'b0;
      for (int unsigned i = 0; i < NumCoef; i++) coef_q[i] <= '0;
      for (int unsigned i = 0; i < NumSnap; i++) snap_q[i] <= '0;
      for (int unsigned i = 0; i < NODES; i++) begin
        node_state_q[i] <= '0;
        vout_q[i]       <= '0;
      end
    end else begin
      fsm_q <= fsm_d;
      if (sample_en && busy) overrun_q <= 1'b1;
      // Out-of-range addresses match no entry and are dropped.
      if (cfg_we && cfg_ready) begin
        for (int unsigned i = 0; i < NumCoef; i++) begin
          if (cfg_addr == AddrW'(i)) coef_q[i] <= cfg_data;
        end
      end
      case (fsm_q)
        StSnap: begin
          node_q <= '0;
          k_q    <= '0;
          for (int unsigned i = 0; i < NumSnap; i++) snap_q[i] <= node_in[i*DW +: DW];
        end
        StMac: k_q <= k_q + 2'd1;
        StWb: begin
          node_state_q[node_q] <= res;
          if (!last_node) begin
            node_q <= node_q + 1'b1;
          end else begin
            // Load v_out here so it is already visible while out_valid is high.
            for (int unsigned n = 0; n < NODES; n++) begin
              vout_q[n] <= (n == node_idx) ? res : node_state_q[n];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_discrete_node_scheduler.sv
// Self-checking bench for discrete_node_scheduler: table of hand-computed frames,
// hand-written collision / reset sequences, then randomized frames against a model.
module tb_discrete_node_scheduler;

  localparam int unsigned NODES = 4;
  localparam int unsigned DW    = 16;
  localparam int unsigned FRAC  = 14;
  localparam int unsigned AddrW = 4;

  logic clk = 1'b0;
  logic rst, sample_en, cfg_we, cfg_ready, out_valid, busy, overrun;
  logic [NODES*3*DW-1:0] node_in;
  logic [AddrW-1:0]      cfg_addr;
  logic [DW-1:0]         cfg_data;
  logic [NODES*DW-1:0]   v_out;

  always #5 clk = ~clk;

  discrete_node_scheduler #(
    .NODES     (NODES),
    .DW        (DW),
    .COEF_FRAC (FRAC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .node_in   (node_in),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .v_out     (v_out),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain integer arithmetic on the update equation.
  longint m_coef  [NODES*4];
  longint m_state [NODES];
  longint m_in    [NODES][3];

  typedef struct {
    longint in_n0;   // node0 in0
    longint in_n1;   // node1 in0..in2
    longint exp_n0;
    longint exp_n1;
  } vec_t;
  vec_t tbl [5];

  int c, nv, vc, acc_c;
  bit accept;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint vout_of(input int n);
    return longint'($signed(v_out[n*DW +: DW]));
  endfunction

  function automatic longint clamp(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint rnd16();
    return longint'($signed(16'($urandom())));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NODES * 4; i++) m_coef[i] = 0;
    for (int n = 0; n < NODES; n++) begin
      m_state[n] = 0;
      for (int k = 0; k < 3; k++) m_in[n][k] = 0;
    end
  endtask

  task automatic model_frame();
    longint s;
    for (int n = 0; n < NODES; n++) begin
      s = m_coef[n*4] * m_state[n];
      for (int k = 0; k < 3; k++) s += m_coef[n*4+1+k] * m_in[n][k];
      m_state[n] = clamp(s >>> FRAC);
    end
  endtask

  task automatic drive_inputs();
    for (int n = 0; n < NODES; n++)
      for (int k = 0; k < 3; k++) node_in[(n*3+k)*DW +: DW] = DW'(m_in[n][k]);
  endtask

  task automatic check_vout(input string tag);
    for (int n = 0; n < NODES; n++)
      check($sformatf("%s v_out[%0d]", tag, n), vout_of(n), m_state[n]);
  endtask

  task automatic cfg_write(input int addr, input longint data);
    cfg_we   = 1'b1;
    cfg_addr = AddrW'(addr);
    cfg_data = DW'(data);
    step();
    cfg_we   = 1'b0;
    m_coef[addr] = data;
  endtask

  // Starts a frame from idle and checks latency, result and return to idle.
  task automatic run_frame(input string tag, input bit with_cfg, input int addr,
                           input longint data);
    int cyc;
    if (with_cfg) begin
      cfg_we   = 1'b1;
      cfg_addr = AddrW'(addr);
      cfg_data = DW'(data);
    end
    sample_en = 1'b1;
    step();
    sample_en = 1'b0;
    cfg_we    = 1'b0;
    if (with_cfg) m_coef[addr] = data;
    check({tag, " busy at T+1"}, longint'(busy), 1);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      step();
      cyc++;
    end
    check({tag, " out_valid cycle"}, cyc, 22);
    model_frame();
    check_vout(tag);
    step();
    check({tag, " out_valid pulse width"}, longint'(out_valid), 0);
    check({tag, " idle at T+23"}, longint'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; sample_en = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    node_in = '0;
    model_reset();
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset out_valid", longint'(out_valid), 0);
    check("reset busy", longint'(busy), 0);
    check("reset cfg_ready", longint'(cfg_ready), 1);
    check("reset overrun", longint'(overrun), 0);
    check_vout("reset");

    // Node0 integrator a=1.0 b0=0.5; node1 b0..b2 = max positive for saturation.
    cfg_write(0, 16384);
    cfg_write(1, 8192);
    cfg_write(5, 32767);
    cfg_write(6, 32767);
    cfg_write(7, 32767);

    tbl[0] = '{in_n0: 1000,  in_n1: 0,      exp_n0: 500,  exp_n1: 0};
    tbl[1] = '{in_n0: 1000,  in_n1: 32767,  exp_n0: 1000, exp_n1: 32767};
    tbl[2] = '{in_n0: -3000, in_n1: -32768, exp_n0: -500, exp_n1: -32768};
    tbl[3] = '{in_n0: 1,     in_n1: 0,      exp_n0: -500, exp_n1: 0};
    tbl[4] = '{in_n0: -1,    in_n1: 100,    exp_n0: -501, exp_n1: 599};
    for (int i = 0; i < 5; i++) begin
      m_in[0][0] = tbl[i].in_n0;
      for (int k = 0; k < 3; k++) m_in[1][k] = tbl[i].in_n1;
      drive_inputs();
      run_frame($sformatf("vec%0d", i), 1'b0, 0, 0);
      check($sformatf("vec%0d node0", i), vout_of(0), tbl[i].exp_n0);
      check($sformatf("vec%0d node1", i), vout_of(1), tbl[i].exp_n1);
      check($sformatf("vec%0d node2", i), vout_of(2), 0);
      check($sformatf("vec%0d node3", i), vout_of(3), 0);
      repeat (17) step();
      check_vout($sformatf("vec%0d hold", i));
    end

    // Overrun: second strobe mid-frame is dropped and latches the flag.
    m_in[0][0] = 2000;
    drive_inputs();
    check("overrun clear before", longint'(overrun), 0);
    sample_en = 1'b1;
    step();
    sample_en = 1'b0;
    c = 1; nv = 0; vc = 0;
    while (c < 35) begin
      if (c == 10) sample_en = 1'b1;
      step();
      sample_en = 1'b0;
      c++;
      if (out_valid) begin
        nv++;
        vc = c;
      end
    end
    model_frame();
    check("overrun out_valid count", nv, 1);
    check("overrun out_valid cycle", vc, 22);
    check("overrun flag", longint'(overrun), 1);
    check_vout("overrun frame");
    repeat (5) step();
    check("overrun sticky", longint'(overrun), 1);

    // Write to a while busy: must wait for cfg_ready, frame keeps old a.
    sample_en = 1'b1;
    step();
    sample_en = 1'b0;
    c = 1; acc_c = 0; vc = 0;
    while (c < 40) begin
      if (c == 5) begin
        cfg_we = 1'b1; cfg_addr = '0; cfg_data = DW'(8192);
        check("cfg_ready low while busy", longint'(cfg_ready), 0);
      end
      accept = cfg_we && cfg_ready;
      step();
      c++;
      if (accept) begin
        acc_c  = c - 1;
        cfg_we = 1'b0;
      end
      if (out_valid) vc = c;
    end
    cfg_we = 1'b0;
    check("cfg busy accept cycle", acc_c, 23);
    check("cfg busy out_valid cycle", vc, 22);
    model_frame();
    check_vout("cfg busy old a");
    m_coef[0] = 8192;
    run_frame("cfg busy new a", 1'b0, 0, 0);

    // Write and strobe in the same cycle: frame must see the new coefficient.
    run_frame("cfg with strobe", 1'b1, 1, 16384);

    // Reset mid-frame.
    sample_en = 1'b1;
    step();
    sample_en = 1'b0;
    c = 1;
    while (c < 12) begin
      step();
      c++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midreset busy", longint'(busy), 0);
    check("midreset cfg_ready", longint'(cfg_ready), 1);
    check("midreset overrun", longint'(overrun), 0);
    check("midreset out_valid", longint'(out_valid), 0);
    model_reset();
    check_vout("midreset");
    nv = 0;
    repeat (30) begin
      step();
      if (out_valid) nv++;
    end
    check("midreset no out_valid", nv, 0);
    for (int n = 0; n < NODES; n++)
      for (int k = 0; k < 3; k++) m_in[n][k] = 12345 - n * 1000 - k * 7;
    drive_inputs();
    run_frame("post reset zero coefs", 1'b0, 0, 0);

    // Randomized frames at up to the minimum sample period.
    for (int i = 0; i < NODES * 4; i++)
      cfg_write(i, ($urandom_range(0, 3) == 0) ? rnd16() : (rnd16() >>> 1));
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 4))
          cfg_write(int'($urandom_range(0, NODES * 4 - 1)), rnd16() >>> 1);
      end
      for (int n = 0; n < NODES; n++)
        for (int k = 0; k < 3; k++) m_in[n][k] = rnd16();
      drive_inputs();
      repeat ($urandom_range(0, 3)) step();
      run_frame($sformatf("rand%0d", f), 1'b0, 0, 0);
    end
    check("no overrun at min period", longint'(overrun), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
